// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator controller: FSM states,
// keypad codes, ALU opcodes and a BCD digit-shift helper.
package calc_pkg;

    typedef enum logic [2:0] {
        OP1      = 3'd0,
        OP2_WAIT = 3'd1,
        OP2      = 3'd2,
        EXEC     = 3'd3,
        RESULT   = 3'd4,
        ERROR    = 3'd5
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_EQU = 4'hC;
    localparam logic [3:0] KEY_CLR = 4'hD;
    localparam logic [3:0] KEY_NEG = 4'hE;
    localparam logic [3:0] KEY_RSV = 4'hF;

    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] SUB = 3'b010;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_arith(input logic [3:0] code);
        return (code == KEY_ADD) || (code == KEY_SUB);
    endfunction

    function automatic logic [2:0] key_to_opc(input logic [3:0] code);
        return (code == KEY_SUB) ? SUB : ADD;
    endfunction

    // Shift a new units digit in; once the tens digit is occupied the operand is full.
    function automatic logic [8:0] shift_digit(input logic [8:0] op, input logic [3:0] digit);
        return (op[7:4] != 4'd0) ? op : {op[8], op[3:0], digit};
    endfunction

endpackage

// File: rtl/calc_controller_if.sv
// Keypad/display bundle between the calculator controller and its host.
interface calc_controller_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [8:0] disp_value;
    logic       disp_err;
    logic       busy;

    modport master (
        output key_valid, key_code,
        input  key_ready, disp_value, disp_err, busy
    );

    modport slave (
        input  key_valid, key_code,
        output key_ready, disp_value, disp_err, busy
    );
endinterface

// File: rtl/calc_controller_alu.sv
// Combinational sign-magnitude two-digit BCD adder/subtractor; ovf flags
// any result whose magnitude exceeds 99.
module alu
    import calc_pkg::*;
(
    input  logic [8:0] a,
    input  logic [8:0] b,
    input  logic [2:0] opcode,
    output logic [8:0] y,
    output logic       ovf
);

    logic [6:0]        a_mag;
    logic [6:0]        b_mag;
    logic signed [9:0] a_s;
    logic signed [9:0] b_s;
    logic signed [9:0] r_s;
    logic [9:0]        r_abs;
    logic [3:0]        tens;
    logic [3:0]        units;

    always_comb begin
        a_mag = 7'(a[7:4]) * 7'd10 + 7'(a[3:0]);
        b_mag = 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
        a_s   = a[8] ? -$signed({3'b000, a_mag}) : $signed({3'b000, a_mag});
        b_s   = b[8] ? -$signed({3'b000, b_mag}) : $signed({3'b000, b_mag});
        case (opcode)
            ADD:     r_s = a_s + b_s;
            SUB:     r_s = a_s - b_s;
            default: r_s = '0;
        endcase
        r_abs = r_s[9] ? $unsigned(-r_s) : $unsigned(r_s);
        ovf   = r_abs > 10'd99;
        tens  = 4'(r_abs / 10'd10);
        units = 4'(r_abs % 10'd10);
        // A zero result is never negative, so the sign comes straight from r_s.
        y     = {r_s[9], tens, units};
    end

endmodule

// File: rtl/calc_controller.sv
// Keypad-driven two-digit BCD calculator controller.
// Optional result chaining (add/sub pressed on a result) under `CALC_CHAIN_EN.
module calc_controller
    import calc_pkg::*;
(
    input logic         clk,
    input logic         rst,
    calc_controller_if.slave bus
);

    state_t     state_q,  state_d;
    logic [8:0] op1_q,    op1_d;
    logic [8:0] op2_q,    op2_d;
    logic [2:0] opcode_q, opcode_d;
    logic [8:0] result_q, result_d;

    logic [8:0] alu_y;
    logic       alu_ovf;
    logic       busy;
    logic       key_acc;
    logic [3:0] code;

    alu u_alu (
        .a      (op1_q),
        .b      (op2_q),
        .opcode (opcode_q),
        .y      (alu_y),
        .ovf    (alu_ovf)
    );

    assign busy    = (state_q == EXEC);
    assign code    = bus.key_code;
    assign key_acc = bus.key_valid && !busy && (code != KEY_RSV);

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        opcode_d = opcode_q;
        result_d = result_q;

        if (key_acc && code == KEY_CLR) begin
            state_d  = OP1;
            op1_d    = '0;
            op2_d    = '0;
            opcode_d = NOP;
            result_d = '0;
        end else begin
            case (state_q)
                OP1: if (key_acc) begin
                    if (is_digit(code)) begin
                        op1_d = shift_digit(op1_q, code);
                    end else if (is_arith(code)) begin
                        opcode_d = key_to_opc(code);
                        state_d  = OP2_WAIT;
                    end else if (code == KEY_NEG && op1_q[7:0] != 8'd0) begin
                        op1_d[8] = ~op1_q[8];
                    end
                end
                OP2_WAIT: if (key_acc) begin
                    if (is_digit(code)) begin
                        op2_d   = {1'b0, 4'd0, code};
                        state_d = OP2;
                    end else if (is_arith(code)) begin
                        opcode_d = key_to_opc(code);
                    end
                end
                OP2: if (key_acc) begin
                    if (is_digit(code)) begin
                        op2_d = shift_digit(op2_q, code);
                    end else if (code == KEY_NEG && op2_q[7:0] != 8'd0) begin
                        op2_d[8] = ~op2_q[8];
                    end else if (code == KEY_EQU) begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    result_d = alu_y;
                    opcode_d = NOP;
                    state_d  = alu_ovf ? ERROR : RESULT;
                end
                RESULT: if (key_acc) begin
                    if (is_digit(code)) begin
                        op1_d   = {1'b0, 4'd0, code};
                        op2_d   = '0;
                        state_d = OP1;
                    end
`ifdef CALC_CHAIN_EN
                    else if (is_arith(code)) begin
                        op1_d    = result_q;
                        op2_d    = '0;
                        opcode_d = key_to_opc(code);
                        state_d  = OP2_WAIT;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= OP1;
            op1_q    <= '0;
            op2_q    <= '0;
            opcode_q <= NOP;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        bus.disp_value = '0;
        case (state_q)
            OP1, OP2_WAIT: bus.disp_value = op1_q;
            OP2, EXEC:     bus.disp_value = op2_q;
            RESULT:        bus.disp_value = result_q;
            default:       bus.disp_value = '0;
        endcase
    end

    assign bus.disp_err  = (state_q == ERROR);
    assign bus.busy      = busy;
    assign bus.key_ready = !busy;

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: key-sequence table plus hand-timed
// EXEC-cycle and reset sequences.
module tb_calc_controller;

    typedef struct {
        logic [3:0] key;
        logic [8:0] disp;
        logic       err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    calc_controller_if bus();

    calc_controller u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] k, input logic [8:0] d, input logic e);
        vec_t v;
        v.key  = k;
        v.disp = d;
        v.err  = e;
        vecs.push_back(v);
    endfunction

    // Drive a one-cycle key strobe; returns on the falling edge after the accepting edge.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic press_idle(input logic [3:0] k);
        press(k);
        @(negedge clk);
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;

        // Keys: D=clear A=add B=sub C=equals E=negate F=reserved
        add(4'hD, 9'h000, 0); add(4'h1, 9'h001, 0); add(4'h2, 9'h012, 0); add(4'hA, 9'h012, 0);
        add(4'h3, 9'h003, 0); add(4'h4, 9'h034, 0); add(4'hC, 9'h046, 0);
        add(4'hD, 9'h000, 0); add(4'h2, 9'h002, 0); add(4'h5, 9'h025, 0); add(4'hB, 9'h025, 0);
        add(4'h4, 9'h004, 0); add(4'h0, 9'h040, 0); add(4'hC, 9'h115, 0);
        add(4'hD, 9'h000, 0); add(4'h9, 9'h009, 0); add(4'h9, 9'h099, 0); add(4'hA, 9'h099, 0);
        add(4'h0, 9'h000, 0); add(4'h1, 9'h001, 0); add(4'hC, 9'h000, 1); add(4'h7, 9'h000, 1);
        add(4'hC, 9'h000, 1); add(4'hE, 9'h000, 1); add(4'hD, 9'h000, 0);
        add(4'h1, 9'h001, 0); add(4'h2, 9'h012, 0); add(4'h3, 9'h012, 0); add(4'hE, 9'h112, 0);
        add(4'h4, 9'h112, 0);
        add(4'hD, 9'h000, 0); add(4'hE, 9'h000, 0); add(4'h5, 9'h005, 0); add(4'hE, 9'h105, 0);
        add(4'h6, 9'h156, 0); add(4'hF, 9'h156, 0); add(4'hA, 9'h156, 0); add(4'hB, 9'h156, 0);
        add(4'h2, 9'h002, 0); add(4'hE, 9'h102, 0); add(4'hC, 9'h154, 0); add(4'hC, 9'h154, 0);
        add(4'hE, 9'h154, 0); add(4'h7, 9'h007, 0);
        add(4'hD, 9'h000, 0); add(4'h3, 9'h003, 0); add(4'hA, 9'h003, 0); add(4'hC, 9'h003, 0);
        add(4'hE, 9'h003, 0); add(4'h4, 9'h004, 0); add(4'hA, 9'h004, 0); add(4'hC, 9'h007, 0);
        add(4'hD, 9'h000, 0); add(4'h5, 9'h005, 0); add(4'hB, 9'h005, 0); add(4'h5, 9'h005, 0);
        add(4'hC, 9'h000, 0);
        add(4'hD, 9'h000, 0); add(4'h3, 9'h003, 0); add(4'hE, 9'h103, 0); add(4'hA, 9'h103, 0);
        add(4'h1, 9'h001, 0); add(4'hC, 9'h102, 0);
        add(4'hD, 9'h000, 0); add(4'h9, 9'h009, 0); add(4'h9, 9'h099, 0); add(4'hA, 9'h099, 0);
        add(4'h0, 9'h000, 0); add(4'hC, 9'h099, 0);
        add(4'hD, 9'h000, 0); add(4'h9, 9'h009, 0); add(4'h9, 9'h099, 0); add(4'hE, 9'h199, 0);
        add(4'hB, 9'h199, 0); add(4'h1, 9'h001, 0); add(4'hC, 9'h000, 1); add(4'hD, 9'h000, 0);
        add(4'h1, 9'h001, 0); add(4'h0, 9'h010, 0); add(4'hA, 9'h010, 0); add(4'h5, 9'h005, 0);
        add(4'hC, 9'h015, 0); add(4'hA, 9'h015, 0); add(4'h3, 9'h003, 0);
`ifdef CALC_CHAIN_EN
        add(4'hC, 9'h018, 0);
`else
        add(4'hC, 9'h003, 0);
`endif

        // Reset state, held and released
        @(negedge clk);
        check("rst_disp",  bus.disp_value, 9'h000);
        check("rst_ready", 9'(bus.key_ready), 9'h001);
        check("rst_busy",  9'(bus.busy), 9'h000);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_err", 9'(bus.disp_err), 9'h000);

        foreach (vecs[i]) begin
            press_idle(vecs[i].key);
            $display("[TB] vec %0d key=%h disp=0x%03h err=%0d (exp 0x%03h/%0d)",
                     i, vecs[i].key, bus.disp_value, bus.disp_err, vecs[i].disp, vecs[i].err);
            check($sformatf("vec%0d_disp", i), bus.disp_value, vecs[i].disp);
            check($sformatf("vec%0d_err", i),  9'(bus.disp_err), 9'(vecs[i].err));
        end

        // EXEC timing and a key dropped while busy
        press_idle(4'hD); press_idle(4'h1); press_idle(4'h2); press_idle(4'hA);
        press_idle(4'h3); press_idle(4'h4);
        press(4'hC);
        check("exec_busy",  9'(bus.busy), 9'h001);
        check("exec_ready", 9'(bus.key_ready), 9'h000);
        check("exec_disp",  bus.disp_value, 9'h034);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h5;
        @(negedge clk);
        bus.key_valid = 1'b0;
        $display("[TB] seq exec_drop disp=0x%03h busy=%0d", bus.disp_value, bus.busy);
        check("drop_disp_n2", bus.disp_value, 9'h046);
        check("drop_busy",    9'(bus.busy), 9'h000);
        @(negedge clk);
        check("drop_disp_hold", bus.disp_value, 9'h046);

        // Asynchronous reset in the middle of EXEC
        press_idle(4'hD); press_idle(4'h2); press_idle(4'hA); press_idle(4'h7);
        press(4'hC);
        check("pre_rst_busy", 9'(bus.busy), 9'h001);
        #1 rst = 1'b1;
        #1;
        $display("[TB] seq rst_mid_exec disp=0x%03h busy=%0d ready=%0d", bus.disp_value, bus.busy, bus.key_ready);
        check("arst_disp",  bus.disp_value, 9'h000);
        check("arst_err",   9'(bus.disp_err), 9'h000);
        check("arst_busy",  9'(bus.busy), 9'h000);
        check("arst_ready", 9'(bus.key_ready), 9'h001);
        @(negedge clk);
        rst = 1'b0;
        press_idle(4'h1); press_idle(4'h2); press_idle(4'h3);
        $display("[TB] seq post_rst_keys disp=0x%03h", bus.disp_value);
        check("arst_keys_disp", bus.disp_value, 9'h012);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port key_valid, input, 1: single-cycle key strobe.
REQ-004 SHALL have port key_code, input, 4: key codes are 0x0-0x9 digit, 0xA add, 0xB subtract, 0xC equals, 0xD clear, 0xE negate, 0xF reserved.
REQ-005 SHALL have port key_ready, output, 1: high when a key is accepted this cycle.
REQ-006 SHALL have port disp_value, output, 9: sign-magnitude, bit 8 is the sign, bits 7:4 are the tens BCD digit, bits 3:0 are the units BCD digit.
REQ-007 SHALL have port disp_err, output, 1: overflow error indicator.
REQ-008 SHALL have port busy, output, 1: high while an execution is in flight.

Function
REQ-009 SHALL hold registers op1_q[8:0], op2_q[8:0], opcode_q[2:0] and result_q[8:0].
REQ-010 SHALL use FSM states OP1, OP2_WAIT, OP2, EXEC, RESULT and ERROR.
REQ-011 SHALL make key_ready equal to NOT busy; a key_valid received while busy is dropped silently; reserved code 0xF is ignored in every state.
REQ-012 SHALL shift in digits as op = {sign, units_old, digit}; a third digit when tens is nonzero is ignored; digit entry never changes the sign.
REQ-013 SHALL handle OP1 keys as follows: digit shifts into op1_q; add/sub latch opcode_q (001 add, 010 sub) and go to OP2_WAIT; negate toggles op1_q[8] unless the magnitude is 0; equals is ignored.
REQ-014 SHALL handle OP2_WAIT keys as follows: digit loads op2_q = {0,0000,digit} and goes to OP2; add/sub overwrite opcode_q; equals and negate are ignored.
REQ-015 SHALL handle OP2 keys as follows: digit shifts into op2_q; negate toggles op2_q[8] unless the magnitude is 0; equals goes to EXEC; add/sub are ignored.
REQ-016 SHALL last exactly one cycle in EXEC, with busy=1.
- On leaving EXEC, capture ALU result into result_q and go to RESULT if the overflow flag is 0, else ERROR.
REQ-017 SHALL give equals accepted in cycle N this timing: EXEC in cycle N+1, disp_value showing the result from cycle N+2.
REQ-018 SHALL handle RESULT keys as follows: digit starts a new op1 = {0,0000,digit} and goes to OP1; equals and negate are ignored.
- add/sub behaviour in RESULT is set by REQ-024.
REQ-019 SHALL accept only clear in ERROR; disp_value=0 and disp_err=1 in ERROR.
REQ-020 SHALL, on clear in any non-EXEC state, zero op1_q, op2_q, opcode_q and result_q and go to OP1 on the next edge.
REQ-021 SHALL drive disp_value from op1_q in OP1 and OP2_WAIT, from op2_q in OP2 and EXEC, and from result_q in RESULT.
REQ-022 SHALL drive the ALU continuously from op1_q, op2_q and opcode_q; opcode_q=000 outside an armed operation.

Reset
REQ-023 SHALL, on rst asserted at any time (including mid-EXEC), immediately enter OP1 with all registers 0, disp_value=0, disp_err=0, busy=0 and key_ready=1.

Configuration
REQ-024 SHALL implement result chaining under macro CALC_CHAIN_EN.
- When defined: add/sub in RESULT loads op1_q=result_q, latches opcode_q and goes to OP2_WAIT.
- When undefined: add/sub in RESULT is ignored.

Structure
REQ-025 SHALL place the state enum, key-code constants and ALU opcode constants (ADD=3'b001, SUB=3'b010, NOP=3'b000) in a shared package calc_pkg.
REQ-026 SHALL instantiate the existing combinational BCD adder/subtractor sub-module alu exactly once; no other sub-modules.

Verification
REQ-027 SHALL cover: keys 1,2,+,3,4,= -> disp_value=9'h046 two cycles after =, disp_err=0.
REQ-028 SHALL cover: keys 2,5,-,4,0,= -> disp_value=9'h115 (i.e. -15).
REQ-029 SHALL cover: keys 9,9,+,0,1,= -> ERROR, disp_err=1; then keys 7 and = ignored; then clear -> OP1 with disp_value=0.
REQ-030 SHALL cover: key 5 pulsed in the EXEC cycle -> dropped (key_ready=0); result unchanged.
REQ-031 SHALL cover: with CALC_CHAIN_EN, keys 1,0,+,5,=,+,3,= -> disp_value=9'h018; without it, the second + is ignored and the display holds 9'h015.
REQ-032 SHALL cover: rst asserted mid-EXEC -> all outputs 0 asynchronously and key_ready=1; keys 1,2,3 -> disp_value=9'h012.
